// File: rtl/kbd_cmd_ctrl.sv
// PS/2 scan-code sequencer: pops the receiver FIFO, tracks E0/F0 prefixes and
// turns arrow/WASD/Enter/R keys into valid/ready game commands plus a held-direction vector.
module kbd_cmd_ctrl #(
   parameter int TIMEOUT_CYC = 50000,
   parameter int TW          = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_r_data,
   output logic       fifo_rd,
   output logic       cmd_valid,
   output logic [2:0] cmd,
   input  logic       cmd_ready,
   output logic [3:0] held
);

   localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC);

   typedef enum logic {IDLE, DECODE} state_t;

   state_t        state, state_nxt;
   logic [7:0]    code_reg;
   logic          ext, brk, ext_nxt, brk_nxt;
   logic [TW-1:0] tmo, tmo_nxt, tmo_inc;
   logic          fifo_rd_nxt, cmd_valid_nxt;
   logic [2:0]    cmd_nxt;
   logic [3:0]    held_nxt;
   logic          pop;
   logic [3:0]    key_res;
   logic          key_hit;
   logic [2:0]    key_cmd;

   // Result is {hit, cmd}; the table in use depends on whether E0 preceded the byte.
   function automatic logic [3:0] key_map(input logic [7:0] code, input logic ext_f);
      logic [3:0] r;
      r = 4'b0000;
      if (ext_f) begin
         case (code)
            8'h75:   r = 4'b1000;
            8'h72:   r = 4'b1001;
            8'h6B:   r = 4'b1010;
            8'h74:   r = 4'b1011;
            default: r = 4'b0000;
         endcase
      end else begin
         case (code)
            8'h1D:   r = 4'b1000;
            8'h1B:   r = 4'b1001;
            8'h1C:   r = 4'b1010;
            8'h23:   r = 4'b1011;
            8'h5A:   r = 4'b1100;
            8'h2D:   r = 4'b1101;
            default: r = 4'b0000;
         endcase
      end
      return r;
   endfunction

   function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign pop     = (state == IDLE) && !fifo_empty && !cmd_valid;
   assign key_res = key_map(code_reg, ext);
   assign key_hit = key_res[3];
   assign key_cmd = key_res[2:0];
   assign tmo_inc = sat_inc(tmo);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pop) state_nxt = DECODE;
         DECODE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      fifo_rd_nxt   = pop;
      cmd_valid_nxt = cmd_valid & ~cmd_ready;
      cmd_nxt       = cmd;
      held_nxt      = held;
      ext_nxt       = ext;
      brk_nxt       = brk;
      tmo_nxt       = tmo;
      case (state)
         IDLE: begin
            // A dangling prefix is dropped once the FIFO has stayed dry long enough.
            if ((ext | brk) && fifo_empty) begin
               if (tmo_inc >= TMO_LIM) begin
                  ext_nxt = 1'b0;
                  brk_nxt = 1'b0;
                  tmo_nxt = '0;
               end else begin
                  tmo_nxt = tmo_inc;
               end
            end
         end
         DECODE: begin
            if (code_reg == 8'hE0) begin
               ext_nxt = 1'b1;
               tmo_nxt = '0;
            end else if (code_reg == 8'hF0) begin
               brk_nxt = 1'b1;
               tmo_nxt = '0;
            end else begin
               ext_nxt = 1'b0;
               brk_nxt = 1'b0;
               tmo_nxt = '0;
               if (key_hit) begin
                  if (!brk) begin
                     cmd_nxt       = key_cmd;
                     cmd_valid_nxt = 1'b1;
                     if (!key_cmd[2]) held_nxt[key_cmd[1:0]] = 1'b1;
                  end else if (!key_cmd[2]) begin
                     held_nxt[key_cmd[1:0]] = 1'b0;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_rd   <= 1'b0;
         cmd_valid <= 1'b0;
         cmd       <= 3'd0;
         held      <= 4'd0;
         ext       <= 1'b0;
         brk       <= 1'b0;
         tmo       <= '0;
      end else begin
         fifo_rd   <= fifo_rd_nxt;
         cmd_valid <= cmd_valid_nxt;
         cmd       <= cmd_nxt;
         held      <= held_nxt;
         ext       <= ext_nxt;
         brk       <= brk_nxt;
         tmo       <= tmo_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (pop) code_reg <= fifo_r_data;
   end

endmodule

// File: tb/tb_kbd_cmd_ctrl.sv
// Scoreboard bench for kbd_cmd_ctrl: a byte-stream key model predicts commands,
// a negedge monitor pops and compares each presented command.
module tb_kbd_cmd_ctrl;
   localparam int TMO = 200;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_r_data = 8'h00;
   logic       fifo_rd;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic       cmd_ready = 1'b0;
   logic [3:0] held;

   logic [7:0] fifo_q[$];
   logic [6:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         rd_cnt = 0;
   bit         rand_rdy = 1'b0;

   logic       m_ext, m_brk;
   logic [3:0] m_held;
   logic [7:0] ext_codes[4]   = '{8'h75, 8'h72, 8'h6B, 8'h74};
   logic [7:0] plain_codes[6] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h2D};
   logic [7:0] pool[15] = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                            8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h2D, 8'h15};

   always #5 clk = ~clk;

   kbd_cmd_ctrl #(.TIMEOUT_CYC(TMO), .TW(16)) dut (
      .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
      .fifo_rd(fifo_rd), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .held(held)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int lookup(input logic [7:0] b, input logic e);
      if (e) begin
         for (int i = 0; i < 4; i++) if (ext_codes[i] == b) return i;
      end else begin
         for (int i = 0; i < 6; i++) if (plain_codes[i] == b) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ext = 1'b0; m_brk = 1'b0; m_held = 4'b0000;
   endtask

   task automatic model_byte(input logic [7:0] b);
      int k;
      if (b == 8'hE0) m_ext = 1'b1;
      else if (b == 8'hF0) m_brk = 1'b1;
      else begin
         k = lookup(b, m_ext);
         if (k >= 0) begin
            if (!m_brk) begin
               if (k < 4) m_held[k] = 1'b1;
               exp_q.push_back({k[2:0], m_held});
            end else if (k < 4) begin
               m_held[k] = 1'b0;
            end
         end
         m_ext = 1'b0; m_brk = 1'b0;
      end
   endtask

   task automatic upd_fifo();
      fifo_empty = (fifo_q.size() == 0);
      if (fifo_q.size() > 0) fifo_r_data = fifo_q[0];
      else fifo_r_data = 8'h00;
   endtask

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      model_byte(b);
      upd_fifo();
   endtask

   // One clock: FIFO pops on the edge when fifo_rd was high; returns at posedge+1.
   task automatic tick();
      logic rd_s;
      @(negedge clk);
      rd_s = fifo_rd;
      if (rd_s) rd_cnt++;
      @(posedge clk);
      if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
      #1;
      upd_fifo();
      if (rand_rdy) cmd_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (!(fifo_q.size() == 0 && fifo_rd == 1'b0 && cmd_valid == 1'b0) && n < budget) begin
         tick();
         n++;
      end
      chk("idle_reached", 32'(n < budget), 1);
      tick();
   endtask

   task automatic wait_valid(input int budget);
      int n;
      n = 0;
      while (!cmd_valid && n < budget) begin
         tick();
         n++;
      end
      chk("valid_reached", 32'(cmd_valid), 1);
   endtask

   initial begin : monitor
      logic       shown;
      logic [2:0] last;
      logic [6:0] e;
      shown = 1'b0;
      last  = 3'd0;
      forever begin
         @(negedge clk);
         if (!reset) shown = 1'b0;
         else if (cmd_valid) begin
            if (!shown) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_cmd actual=%0d expected=none at %0t", cmd, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("cmd", 32'(cmd), 32'(e[6:4]));
                  chk("held_at_cmd", 32'(held), 32'(e[3:0]));
               end
               shown = 1'b1;
               last  = cmd;
            end else begin
               chk("cmd_stable", 32'(cmd), 32'(last));
            end
            chk("no_pop_while_valid", 32'(fifo_rd), 0);
            if (cmd_ready) shown = 1'b0;
         end
      end
   end

   initial begin : main
      int r0;
      model_reset();
      repeat (3) tick();
      chk("rst_fifo_rd", 32'(fifo_rd), 0);
      chk("rst_cmd_valid", 32'(cmd_valid), 0);
      chk("rst_cmd", 32'(cmd), 0);
      chk("rst_held", 32'(held), 0);
      reset = 1'b1;
      repeat (2) tick();

      // Extended UP: two pops then a command
      cmd_ready = 1'b0;
      r0 = rd_cnt;
      push_byte(8'hE0);
      push_byte(8'h75);
      wait_valid(20);
      chk("t1_pops", 32'(rd_cnt - r0), 2);
      chk("t1_cmd", 32'(cmd), 0);
      chk("t1_held", 32'(held), 1);
      cmd_ready = 1'b1;
      tick();
      chk("t1_accept", 32'(cmd_valid), 0);

      // Extended break of UP, then WASD LEFT
      push_byte(8'hE0); push_byte(8'hF0); push_byte(8'h75);
      wait_idle(50);
      chk("t2_release", 32'(held), 0);
      push_byte(8'h1C);
      wait_idle(50);
      chk("t2_left", 32'(held), 4);

      // Backpressure: START held unaccepted while REGEN waits in the FIFO
      cmd_ready = 1'b0;
      push_byte(8'h5A); push_byte(8'h2D);
      wait_valid(20);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_cmd_hold", 32'(cmd), 4);
         chk("t3_valid_hold", 32'(cmd_valid), 1);
         chk("t3_no_pop", 32'(fifo_rd), 0);
      end
      cmd_ready = 1'b1;
      tick();
      chk("t3_accept", 32'(cmd_valid), 0);
      chk("t3_pop_gap", 32'(fifo_rd), 0);
      tick();
      chk("t3_next_pop", 32'(fifo_rd), 1);
      wait_idle(50);
      chk("t3_held", 32'(held), 32'(m_held));

      // Prefix timeout: stale E0 dropped, plain 75 is unmapped
      push_byte(8'hE0);
      wait_idle(50);
      repeat (TMO + 2) tick();
      m_ext = 1'b0; m_brk = 1'b0;
      push_byte(8'h75);
      wait_idle(50);
      chk("t4_held", 32'(held), 32'(m_held));
      chk("t4_no_cmd", 32'(exp_q.size()), 0);

      // Unmapped byte clears a prefix; then RIGHT with N+2 latency
      push_byte(8'hE0); push_byte(8'h15);
      wait_idle(50);
      chk("t5_no_cmd", 32'(exp_q.size()), 0);
      push_byte(8'h23);
      tick();
      chk("t5_rd_n1", 32'(fifo_rd), 1);
      chk("t5_valid_n1", 32'(cmd_valid), 0);
      tick();
      chk("t5_valid_n2", 32'(cmd_valid), 1);
      chk("t5_cmd", 32'(cmd), 3);
      chk("t5_held", 32'(held), 12);
      wait_idle(50);

      // Async reset during DECODE
      push_byte(8'h1D);
      r0 = 0;
      while (!fifo_rd && r0 < 10) begin tick(); r0++; end
      chk("t6_in_decode", 32'(fifo_rd), 1);
      reset = 1'b0;
      #1;
      chk("t6_rd_async", 32'(fifo_rd), 0);
      chk("t6_valid_async", 32'(cmd_valid), 0);
      chk("t6_cmd_async", 32'(cmd), 0);
      chk("t6_held_async", 32'(held), 0);
      fifo_q.delete(); exp_q.delete(); model_reset(); upd_fifo();
      tick();
      reset = 1'b1;
      tick();

      // Async reset with a command pending
      cmd_ready = 1'b0;
      push_byte(8'h5A);
      wait_valid(20);
      reset = 1'b0;
      #1;
      chk("t6b_valid_async", 32'(cmd_valid), 0);
      chk("t6b_cmd_async", 32'(cmd), 0);
      fifo_q.delete(); exp_q.delete(); model_reset(); upd_fifo();
      tick();
      reset = 1'b1;
      tick();
      cmd_ready = 1'b1;
      push_byte(8'hF0); push_byte(8'h1D);
      wait_idle(50);
      chk("t6b_held", 32'(held), 0);
      chk("t6b_no_cmd", 32'(exp_q.size()), 0);
      chk("t6b_valid", 32'(cmd_valid), 0);

      // Randomized byte stream with random ready
      rand_rdy = 1'b1;
      for (int i = 0; i < 200; i++) begin
         int n;
         push_byte(pool[$urandom_range(0, 14)]);
         repeat ($urandom_range(0, 6)) tick();
         n = 0;
         while (fifo_q.size() >= 2 && n < 100) begin tick(); n++; end
      end
      rand_rdy = 1'b0;
      cmd_ready = 1'b1;
      push_byte(8'h15);
      wait_idle(400);
      chk("rand_held", 32'(held), 32'(m_held));
      chk("rand_drained", 32'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/kbd_cmd_ctrl.md
Name: kbd_cmd_ctrl

Overview:
- Sequences the one-entry PS/2 scan-code FIFO that sits between the keyboard receiver and the maze game logic.
- Pops one byte at a time and tracks the E0 (extended) and F0 (break) prefixes.
- Decodes arrow/WASD/Enter/R keys into game commands and presents each command on a valid/ready handshake to the maze FSM.
- Maintains a held-direction vector from make/break pairs; backpressures the FIFO while a command is unaccepted.

Parameters:
TIMEOUT_CYC, 50000, cycles a prefix (E0/F0) stays pending without a following byte before it is discarded
TW, 16, width of prefix timeout counter; must satisfy 2^TW > TIMEOUT_CYC

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
fifo_empty  input  1  FIFO empty flag
fifo_r_data  input  8  FIFO head byte, valid when fifo_empty=0
fifo_rd  output  1  one-cycle pop strobe to FIFO, registered
cmd_valid  output  1  command available, registered
cmd  output  3  command code: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 START, 5 REGEN; 6,7 unused
cmd_ready  input  1  maze FSM accepts cmd when cmd_valid & cmd_ready
held  output  4  key currently held: bit0 up, bit1 down, bit2 left, bit3 right

Behaviour:
- Reset (reset=0, async): state=IDLE, fifo_rd=0, cmd_valid=0, cmd=0, held=0, ext=0, brk=0, timeout counter=0. Reset mid-byte or mid-handshake discards everything; a popped byte is lost.
- States: IDLE, DECODE.
- IDLE:
  - If fifo_empty=0 and cmd_valid=0: code_reg<=fifo_r_data, fifo_rd<=1, go DECODE.
  - Otherwise stay. No pop while cmd_valid=1, including the cycle where cmd_ready=1.
- DECODE (exactly one cycle): fifo_rd<=0, always return to IDLE. By then the FIFO empty flag has updated. Decode rules:
  - code E0: ext<=1, restart timeout.
  - code F0: brk<=1, restart timeout.
  - Any other code: terminal byte; ext<=0 and brk<=0 after use.
- Key map, terminal byte with prefixes:
  - ext=1: 75 UP, 72 DOWN, 6B LEFT, 74 RIGHT.
  - ext=0: 1D UP, 1B DOWN, 1C LEFT, 23 RIGHT, 5A START, 2D REGEN.
  - Any other code is ignored: no command, no held change, prefixes still cleared.
- Make (brk=0), mapped key: cmd<=code, cmd_valid<=1. For a direction, set the matching held bit. Typematic repeats produce repeated commands.
- Break (brk=1), mapped direction: clear the held bit, no command. Break of START/REGEN/unmapped keys: no effect.
- Latency: byte at FIFO head with IDLE and cmd_valid=0 in cycle N gives fifo_rd=1 in N+1 and cmd_valid=1 in N+2.
- Handshake:
  - cmd_valid stays high and cmd stays stable until a cycle with cmd_ready=1; cmd_valid clears on that edge.
  - Next pop earliest one cycle later.
  - cmd_ready while cmd_valid=0 has no effect.
- Timeout:
  - Counter runs while (ext|brk)=1 and the state is IDLE with fifo_empty=1.
  - At TIMEOUT_CYC it clears ext, brk and the counter.
  - A new byte popped before expiry restarts the counter only if that byte is itself a prefix.
- Held vector: the same key pressed via arrow and WASD sets the same bit; either release clears it. held is independent of cmd handshake state.
- Counter width: TW bits, saturates, never wraps.

Test Plan:
- Reset release, push E0 then 75 (each pop observed): exactly two fifo_rd pulses, then cmd_valid=1, cmd=0, held=4'b0001. cmd_ready=1 one cycle later: cmd_valid=0.
- After UP held, push E0,F0,75: held=4'b0000, no cmd_valid pulse. Push 1C: cmd=2, held=4'b0100.
- Push 5A with cmd_ready held 0 for 10 cycles while FIFO holds 2D: cmd=4 stays stable, fifo_rd stays 0. cmd_ready=1: next pop, then cmd=5.
- Push E0 only, wait TIMEOUT_CYC+2 cycles idle, push 75: no UP command (plain 75 unmapped), held unchanged.
- Push unmapped 0x15: one pop, no cmd_valid, ext/brk clear. Then push 23: cmd=3 at N+2 latency.
- Assert reset=0 during DECODE and with cmd_valid=1: outputs go to 0 immediately (asynchronously). After release, a fresh F0,1D sequence does not issue a command.
